fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer between the PC/fetch stage and the instruction memory port. It owns the architectural fetch PC and issues one word-aligned read at a time over a req/gnt/rvalid handshake. It holds the returned instruction for decode under a valid/ready handshake and handles redirects from decode (`branch_i`/`new_pc_i`) at any point, discarding responses that belong to the old path. It replaces the free-running PC increment with memory-latency-tolerant, back-pressure-aware sequencing.

## Interface
- `PC_INIT`, 64'h0000_0000_8000_0000, fetch PC loaded on reset
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `branch_i`  in  1  redirect request from decode, single-cycle pulse
- `new_pc_i`  in  64  redirect target, sampled when `branch_i`=1
- `imem_req_o`  out  1  read request to instruction memory
- `imem_addr_o`  out  64  read address, always `pc` with bits [1:0]=0
- `imem_gnt_i`  in  1  memory accepted request this cycle (req&gnt = accept)
- `imem_rvalid_i`  in  1  read data valid, exactly one per accepted request, ≥1 cycle after accept
- `imem_rdata_i`  in  32  instruction word
- `valid_o`  out  1  `pc_o`/`inst_o` hold a fetched instruction
- `ready_i`  in  1  decode consumes instruction when `valid_o`&`ready_i`
- `pc_o`  out  64  PC of held instruction
- `inst_o`  out  32  held instruction
- `misalign_o`  out  1  one-cycle pulse: redirect target had bits [1:0]≠0

## Operation
- Registers: `pc`[63:0] (next fetch address), `state`, `drop` flag, `hold_pc`, `hold_inst`.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered only from reset; next cycle → REQ.
  - REQ: `imem_req_o`=1, addr=`pc`. On `imem_gnt_i` → WAIT, latch `hold_pc`=`pc`.
  - WAIT: `imem_req_o`=0. On `imem_rvalid_i`: if `drop`=1, clear `drop` and → REQ; else latch `hold_inst`=`imem_rdata_i`, set `pc`=`hold_pc`+4, → HOLD.
  - HOLD: `valid_o`=1. On `ready_i` → REQ.
- Redirect (`branch_i`=1) has priority in every state and sets `pc`=`{new_pc_i[63:2],2'b00}`:
  - REQ without gnt: stay in REQ; address changes next cycle. Withdrawal/change before gnt is legal on this port.
  - REQ with gnt same cycle: old request is accepted → WAIT with `drop`=1.
  - WAIT: set `drop`=1, stay in WAIT; when the response arrives it is discarded, then → REQ with the new pc.
  - WAIT with `imem_rvalid_i` same cycle: response discarded, → REQ.
  - HOLD: held instruction flushed even if `ready_i`=1 that cycle; `valid_o`=0 next cycle, → REQ.
  - IDLE: pc updated, → REQ.
- `misalign_o`=1 the cycle after a redirect with `new_pc_i[1:0]`≠0; the fetch still proceeds at the truncated address.
- PC arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state=IDLE, `pc`=`PC_INIT`, `drop`=0, `imem_req_o`=0, `imem_addr_o`=`PC_INIT`, `valid_o`=0, `pc_o`=0, `inst_o`=0, `misalign_o`=0.
- First `imem_req_o` is asserted the 2nd cycle after `reset` deasserts (IDLE takes one cycle).
- Best case (gnt same cycle as req, rvalid one cycle later, ready held high): `valid_o` rises 2 cycles after the req cycle. One instruction per 3 cycles.
- At most one outstanding request; `imem_req_o` is never high in WAIT or HOLD.
- `pc_o`/`inst_o` are stable while `valid_o`=1 and change only after handshake or flush.
- Reset mid-transaction returns to IDLE immediately. Any in-flight `imem_rvalid_i` after reset with no pending accept is ignored.
- All outputs are registered except `imem_req_o` and `imem_addr_o`, which are decoded from state/`pc`.

## Test plan
- Reset, then gnt immediate, rvalid 1 cycle later with rdata=32'h00000013, ready=1 → req at addr 0x8000_0000; `valid_o` with `pc_o`=0x8000_0000, `inst_o`=0x13; next req at 0x8000_0004.
- Gnt delayed 3 cycles, rvalid delayed 5 cycles → `imem_addr_o` constant while waiting; exactly one `valid_o` per response; no req in WAIT.
- `ready_i`=0 for 4 cycles in HOLD → `valid_o`, `pc_o`, `inst_o` stable; no new req until ready=1.
- `branch_i` with `new_pc_i`=0x8000_0100 while in WAIT → stale response dropped (no `valid_o`); next req at 0x8000_0100; `valid_o` shows `pc_o`=0x8000_0100.
- `branch_i` during HOLD with `ready_i`=1 same cycle, target 0x8000_0200 → `valid_o` drops next cycle; next req at 0x8000_0200. Repeat with gnt and branch in the same REQ cycle → response of the old pc dropped.
- Redirect to 0x8000_0203 → `misalign_o` pulses one cycle; req at 0x8000_0200. Redirect to 0xFFFF_FFFF_FFFF_FFFC → following fetch at 0x0. Reset asserted in WAIT → IDLE, `valid_o`=0, next req at `PC_INIT`.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one read at a time over
// req/gnt/rvalid, holds the returned word for decode and handles redirects.
module fetch_ctrl #(
  parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_i,
  input  logic [63:0] new_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] pc_o,
  output logic [31:0] inst_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  localparam logic [63:0] PC_RST = {PC_INIT[63:2], 2'b00};

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [63:0] redirect_pc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    out_pc_d    = out_pc_q;
    valid_d     = valid_q;
    redirect_pc = {new_pc_i[63:2], 2'b00};
    misalign_d  = branch_i && (new_pc_i[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // A request granted in the redirect cycle is already in flight, so its
        // response must be thrown away.
        if (imem_gnt_i) begin
          state_d   = WAIT;
          hold_pc_d = pc_q;
          drop_d    = branch_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q || branch_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            hold_inst_d = imem_rdata_i;
            out_pc_d    = hold_pc_q;
            pc_d        = hold_pc_q + 64'd4;
            valid_d     = 1'b1;
            state_d     = HOLD;
          end
        end else if (branch_i) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_i || ready_i) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (branch_i) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= PC_RST;
      drop_q      <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
      out_pc_q    <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      out_pc_q    <= out_pc_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign pc_o        = out_pc_q;
  assign inst_o      = hold_inst_q;
  assign misalign_o  = misalign_q;

endmodule
